// File: rtl/branch_sequencer.sv
// Execution-state sequencer for the core: CORE / STALL / BRANCH (forward brace scan) / HALT.
// Optional scan-cycle statistics counter enabled by defining BRANCH_SEQ_STATS_EN.

package branch_seq_pkg;
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_INC = 4'd1,
        OP_DEC = 4'd2,
        OP_MVR = 4'd3,
        OP_MVL = 4'd4,
        OP_OUT = 4'd5,
        OP_IN  = 4'd6,
        OP_CBF = 4'd7,
        OP_CBB = 4'd8,
        OP_HLT = 4'd9
    } op_code;

    typedef enum logic [1:0] {
        CORE_S   = 2'd0,
        STALL_S  = 2'd1,
        BRANCH_S = 2'd2,
        HALT_S   = 2'd3
    } seq_state_t;
endpackage

// state    | meaning
// CORE_S   | core control runs; follows req_state / req_halt
// STALL_S  | one valid cycle with PC advance, core writes blocked
// BRANCH_S | forward scan to the matching CBB, tracking brace depth
// HALT_S   | absorbing; depth and fault frozen for debug
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               fetch_valid,
    input  op_code             instruction,
    input  logic [1:0]         req_state,
    input  logic               req_pc_write,
    input  logic               req_halt,
    output logic [1:0]         seq_state,
    output logic               core_enable,
    output logic               pc_write,
    output logic [DEPTH_W-1:0] depth,
    output logic               halted,
    output logic [1:0]         fault,
    output logic [15:0]        scan_cycles
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_OVERFLOW = 2'd1;
    localparam logic [1:0] FAULT_UNMATCH  = 2'd2;

    seq_state_t         state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [1:0]         fault_q, fault_d;

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        fault_d     = fault_q;
        core_enable = 1'b0;
        pc_write    = 1'b0;
        if (fetch_valid) begin
            case (state_q)
                CORE_S: begin
                    core_enable = 1'b1;
                    if (req_halt) begin
                        state_d = HALT_S;
                    end else begin
                        pc_write = req_pc_write;
                        if (req_state == STALL_S) begin
                            state_d = STALL_S;
                        end else if (req_state == BRANCH_S) begin
                            state_d = BRANCH_S;
                            depth_d = DEPTH_ONE;
                        end
                    end
                end
                STALL_S: begin
                    pc_write = 1'b1;
                    state_d  = CORE_S;
                end
                BRANCH_S: begin
                    pc_write = 1'b1;
                    case (instruction)
                        OP_CBF: begin
                            // overflow is caught before the increment so depth never wraps
                            if (depth_q == DEPTH_MAX) begin
                                state_d  = HALT_S;
                                fault_d  = FAULT_OVERFLOW;
                                pc_write = 1'b0;
                            end else begin
                                depth_d = depth_q + DEPTH_ONE;
                            end
                        end
                        OP_CBB: begin
                            if (depth_q == DEPTH_ONE) begin
                                depth_d = '0;
                                state_d = CORE_S;
                            end else begin
                                depth_d = depth_q - DEPTH_ONE;
                            end
                        end
                        OP_HLT: begin
                            state_d  = HALT_S;
                            fault_d  = FAULT_UNMATCH;
                            pc_write = 1'b0;
                        end
                        default: ;
                    endcase
                end
                HALT_S: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CORE_S;
            depth_q <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
        end
    end

    assign seq_state = state_q;
    assign depth     = depth_q;
    assign fault     = fault_q;
    assign halted    = (state_q == HALT_S);

`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0] scan_q, scan_d;

    always_comb begin
        scan_d = scan_q;
        if (fetch_valid && (state_q == BRANCH_S) && (scan_q != 16'hFFFF)) begin
            scan_d = scan_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    assign scan_cycles = scan_q;
`else
    assign scan_cycles = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: two instances (DEPTH_W=8 and DEPTH_W=2) share stimulus,
// expectations come from a behavioural model and are checked mid-cycle by an independent monitor.
module tb_branch_sequencer;
    import branch_seq_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       fetch_valid = 1'b0;
    op_code     instruction = OP_NOP;
    logic [1:0] req_state = 2'd0;
    logic       req_pc_write = 1'b0;
    logic       req_halt = 1'b0;

    logic [1:0]  a_state, b_state;
    logic        a_ce, b_ce, a_pw, b_pw, a_halted, b_halted;
    logic [7:0]  a_depth;
    logic [1:0]  b_depth;
    logic [1:0]  a_fault, b_fault;
    logic [15:0] a_scan, b_scan;

    branch_sequencer #(.DEPTH_W(8)) u_a (
        .clock(clock), .reset_n(reset_n), .fetch_valid(fetch_valid), .instruction(instruction),
        .req_state(req_state), .req_pc_write(req_pc_write), .req_halt(req_halt),
        .seq_state(a_state), .core_enable(a_ce), .pc_write(a_pw), .depth(a_depth),
        .halted(a_halted), .fault(a_fault), .scan_cycles(a_scan)
    );

    branch_sequencer #(.DEPTH_W(2)) u_b (
        .clock(clock), .reset_n(reset_n), .fetch_valid(fetch_valid), .instruction(instruction),
        .req_state(req_state), .req_pc_write(req_pc_write), .req_halt(req_halt),
        .seq_state(b_state), .core_enable(b_ce), .pc_write(b_pw), .depth(b_depth),
        .halted(b_halted), .fault(b_fault), .scan_cycles(b_scan)
    );

    always #5 clock = ~clock;

`ifdef BRANCH_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // mode: 0 core, 1 stall, 2 scanning, 3 halted
    typedef struct { int mode; int nest; int flt; int scans; } mdl_t;
    typedef struct { int st; int ce; int pw; int dep; int hl; int flt; int scn; } exp_t;

    mdl_t ma = '{0, 0, 0, 0};
    mdl_t mb = '{0, 0, 0, 0};
    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic model_cycle(input mdl_t mi, input int maxd, input bit fv, input op_code op,
                               input int rs, input bit rpw, input bit rh,
                               output mdl_t mo, output exp_t e);
        mo    = mi;
        e.st  = mi.mode;
        e.dep = mi.nest;
        e.flt = mi.flt;
        e.scn = STATS ? mi.scans : 0;
        e.hl  = (mi.mode == 3) ? 1 : 0;
        e.ce  = 0;
        e.pw  = 0;
        if (fv) begin
            if (mi.mode == 0) begin
                e.ce = 1;
                if (rh) mo.mode = 3;
                else begin
                    e.pw = rpw ? 1 : 0;
                    if (rs == 1) mo.mode = 1;
                    else if (rs == 2) begin mo.mode = 2; mo.nest = 1; end
                end
            end else if (mi.mode == 1) begin
                e.pw = 1;
                mo.mode = 0;
            end else if (mi.mode == 2) begin
                e.pw = 1;
                if (mi.scans < 65535) mo.scans = mi.scans + 1;
                if (op == OP_CBF) begin
                    if (mi.nest >= maxd) begin mo.mode = 3; mo.flt = 1; e.pw = 0; end
                    else mo.nest = mi.nest + 1;
                end else if (op == OP_CBB) begin
                    mo.nest = mi.nest - 1;
                    if (mo.nest == 0) mo.mode = 0;
                end else if (op == OP_HLT) begin
                    mo.mode = 3; mo.flt = 2; e.pw = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit fv, input op_code op, input int rs,
                       input bit rpw, input bit rh);
        mdl_t na, nb;
        exp_t ea, eb;
        @(posedge clock);
        #1;
        reset_n      = rst;
        fetch_valid  = fv;
        instruction  = op;
        req_state    = 2'(rs);
        req_pc_write = rpw;
        req_halt     = rh;
        if (!rst) begin
            ma = '{0, 0, 0, 0};
            mb = '{0, 0, 0, 0};
        end
        model_cycle(ma, 255, fv, op, rs, rpw, rh, na, ea);
        model_cycle(mb, 3, fv, op, rs, rpw, rh, nb, eb);
        if (rst) begin
            ma = na;
            mb = nb;
        end
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    function automatic void chk(input string nm, input int inst, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t actual=%0d expected=%0d", nm, inst, $time, act, expv);
        end
    endfunction

    function automatic void cmp_all(input int inst, input exp_t e, input int st, input int ce,
                                    input int pw, input int dep, input int hl, input int flt,
                                    input int scn);
        chk("seq_state", inst, st, e.st);
        chk("core_enable", inst, ce, e.ce);
        chk("pc_write", inst, pw, e.pw);
        chk("depth", inst, dep, e.dep);
        chk("halted", inst, hl, e.hl);
        chk("fault", inst, flt, e.flt);
        chk("scan_cycles", inst, scn, e.scn);
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp_all(0, e, int'(a_state), int'(a_ce), int'(a_pw), int'(a_depth),
                    int'(a_halted), int'(a_fault), int'(a_scan));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp_all(1, e, int'(b_state), int'(b_ce), int'(b_pw), int'(b_depth),
                    int'(b_halted), int'(b_fault), int'(b_scan));
        end
    end

    initial begin
        op_code scan_ops[6];
        scan_ops = '{OP_INC, OP_CBF, OP_DEC, OP_CBB, OP_MVR, OP_CBB};

        // reset and plain CORE operation
        cyc(0, 1, OP_NOP, 0, 1, 0);
        cyc(0, 1, OP_NOP, 0, 1, 0);
        cyc(1, 1, OP_NOP, 0, 1, 0);
        cyc(1, 1, OP_INC, 0, 1, 0);

        // single-cycle stall; requests during STALL are ignored
        cyc(1, 1, OP_NOP, 1, 0, 0);
        cyc(1, 1, OP_NOP, 2, 0, 1);
        cyc(1, 1, OP_NOP, 0, 0, 0);

        // nested scan back to CORE
        cyc(1, 1, OP_CBF, 2, 1, 0);
        foreach (scan_ops[i]) cyc(1, 1, scan_ops[i], 1, 0, 0);
        cyc(1, 1, OP_NOP, 0, 1, 0);

        // fetch bubbles mid-scan
        cyc(1, 1, OP_CBF, 2, 0, 0);
        cyc(1, 1, OP_INC, 0, 0, 0);
        cyc(1, 1, OP_CBF, 0, 0, 1);
        repeat (3) cyc(1, 0, OP_CBB, 0, 1, 0);
        cyc(1, 1, OP_CBB, 0, 0, 0);
        cyc(1, 1, OP_CBB, 0, 0, 0);
        cyc(1, 1, OP_NOP, 0, 1, 0);

        // depth overflow on the narrow instance, then HALT is absorbing
        cyc(0, 1, OP_NOP, 0, 0, 0);
        cyc(1, 1, OP_CBF, 2, 0, 0);
        repeat (3) cyc(1, 1, OP_CBF, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, OP_CBB, i % 3, 1, 0);

        // unmatched brace, then asynchronous reset mid-cycle
        cyc(0, 1, OP_NOP, 0, 0, 0);
        cyc(1, 1, OP_CBF, 2, 0, 0);
        cyc(1, 1, OP_INC, 0, 0, 0);
        cyc(1, 1, OP_HLT, 0, 0, 0);
        cyc(1, 1, OP_NOP, 2, 1, 0);
        cyc(0, 1, OP_NOP, 2, 1, 0);
        cyc(1, 1, OP_NOP, 0, 1, 0);

        // randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            cyc(0, 1, OP_NOP, 0, 0, 0);
            for (int c = 0; c < 40; c++) begin
                int     r;
                op_code op;
                r = int'($urandom_range(0, 15));
                if (r < 5) op = OP_CBF;
                else if (r < 10) op = OP_CBB;
                else if (r == 10 && $urandom_range(0, 3) == 0) op = OP_HLT;
                else op = op_code'($urandom_range(0, 6));
                cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0), op,
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 19) == 0));
            end
        end

        @(negedge clock);
        #1;
        chk("queue_drain", 0, qa.size() + qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
